// File: rtl/vga_plot_pkg.sv
// vga_plot_pkg: shared widths, sweep limits and FSM state type for vga_plot_arbiter
package vga_plot_pkg;
  localparam int DEF_X_W = 8;
  localparam int DEF_Y_W = 7;
  localparam int DEF_C_W = 3;
  localparam int DEF_X_MAX = 159;
  localparam int DEF_Y_MAX = 119;
  typedef enum logic {S_IDLE, S_SWEEP} state_t;
endpackage

// File: rtl/vga_plot_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant (req, ptr start index, en gate -> one-hot grant), nearest request at or above ptr wins
module rr_arbiter
  import vga_plot_pkg::*;
#(
  parameter int N = 4,
  parameter int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant
);
  always_comb begin
    grant = '0;
    for (int k = N - 1; k >= 0; k--)
      if (en && req[(int'(ptr) + k) % N]) grant = N'(1) << ((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin share of the VGA pixel port (CLOCK_50, resetn, req_valid/ready/x/y/color, clear_start/color/busy, VGA_X/Y/COLOR, plot) with a priority clear sweeper; PLOT_COUNT_EN adds plot_count
module vga_plot_arbiter
  import vga_plot_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int X_W = DEF_X_W,
  parameter int Y_W = DEF_Y_W,
  parameter int C_W = DEF_C_W,
  parameter int X_MAX = DEF_X_MAX,
  parameter int Y_MAX = DEF_Y_MAX
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*X_W-1:0] req_x,
  input  logic [NREQ*Y_W-1:0] req_y,
  input  logic [NREQ*C_W-1:0] req_color,
  input  logic              clear_start,
  input  logic [C_W-1:0]    clear_color,
  output logic              clear_busy,
  output logic [X_W-1:0]    VGA_X,
  output logic [Y_W-1:0]    VGA_Y,
  output logic [C_W-1:0]    VGA_COLOR,
  output logic              plot
`ifdef PLOT_COUNT_EN
  ,
  output logic [31:0]       plot_count
`endif
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  state_t state;
  logic [PW-1:0] ptr, gidx;
  logic [X_W-1:0] sx;
  logic [Y_W-1:0] sy;
  logic [C_W-1:0] fill;
  logic xfer, x_end;
  rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
    .req(req_valid), .ptr(ptr), .en(state == S_IDLE), .grant(req_ready)
  );
  assign xfer = |req_ready;
  assign x_end = sx == X_W'(X_MAX);
  assign clear_busy = state == S_SWEEP;
  always_comb begin
    gidx = '0;
    for (int k = 0; k < NREQ; k++)
      if (req_ready[k]) gidx = PW'(k);
  end
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state <= S_IDLE;
      ptr <= '0;
      sx <= '0;
      sy <= '0;
      fill <= '0;
      VGA_X <= '0;
      VGA_Y <= '0;
      VGA_COLOR <= '0;
      plot <= 1'b0;
    end else if (state == S_SWEEP) begin
      VGA_X <= sx;
      VGA_Y <= sy;
      VGA_COLOR <= fill;
      plot <= 1'b1;
      sx <= x_end ? '0 : sx + 1'b1;
      sy <= x_end ? (sy == Y_W'(Y_MAX) ? '0 : sy + 1'b1) : sy;
      if (x_end && sy == Y_W'(Y_MAX)) state <= S_IDLE;
    end else begin
      plot <= xfer;
      if (xfer) begin
        VGA_X <= req_x[gidx*X_W +: X_W];
        VGA_Y <= req_y[gidx*Y_W +: Y_W];
        VGA_COLOR <= req_color[gidx*C_W +: C_W];
        ptr <= gidx == PW'(NREQ - 1) ? '0 : gidx + 1'b1;
      end
      if (clear_start) begin
        state <= S_SWEEP;
        sx <= '0;
        sy <= '0;
        fill <= clear_color;
      end
    end
  end
`ifdef PLOT_COUNT_EN
  always_ff @(posedge CLOCK_50) plot_count <= !resetn ? '0 : plot_count + 32'(plot);
`endif
endmodule
